// File: rtl/fir_pkg.sv
// Shared FIR constants and types: window length, sample width, queue FSM states.
package fir_pkg;

  localparam int unsigned NUM_COEFF = 1021;
  localparam int unsigned DEPTH     = NUM_COEFF;
  localparam int unsigned SMPL_W    = 16;
  localparam int unsigned PTR_W     = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, PRIME, SEQ} q_state_t;

endpackage

// File: rtl/dp_ram.sv
// Sample window storage: one synchronous write port, one combinational read port, no reset.
module dp_ram #(
  parameter int unsigned DEPTH  = 1021,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/smpl_queue.sv
// Circular sample buffer; on each new sample once full, streams the window oldest-first
// on smpl_out with sequencing high for exactly DEPTH cycles.
module smpl_queue #(
  parameter int unsigned DEPTH  = fir_pkg::DEPTH,
  parameter int unsigned ADDR_W = fir_pkg::PTR_W,
  parameter int unsigned DATA_W = fir_pkg::SMPL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wrt_smpl,
  input  logic [DATA_W-1:0] smpl_in,
  output logic              sequencing,
  output logic [DATA_W-1:0] smpl_out,
  output logic              full
);

  import fir_pkg::*;

  localparam int unsigned     CNT_W = $clog2(DEPTH + 1);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  q_state_t          state;
  logic [ADDR_W-1:0] new_ptr, old_ptr, rd_ptr, rd_addr;
  logic [CNT_W-1:0]  cnt, seq_cnt;
  logic              pend;
  logic [DATA_W-1:0] hold, wr_data, rd_data;
  logic              wr_en;

  function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  // Only IDLE touches the window; a held sample takes priority over a fresh strobe.
  always_comb begin
    wr_en   = (state == IDLE) && (pend || wrt_smpl);
    wr_data = pend ? hold : smpl_in;
    rd_addr = (state == PRIME) ? old_ptr : rd_ptr;
  end

  dp_ram #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_ram (
    .clk  (clk),
    .we   (wr_en),
    .waddr(new_ptr),
    .wdata(wr_data),
    .raddr(rd_addr),
    .rdata(rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      new_ptr    <= '0;
      old_ptr    <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      seq_cnt    <= '0;
      pend       <= 1'b0;
      hold       <= '0;
      sequencing <= 1'b0;
      smpl_out   <= '0;
      full       <= 1'b0;
    end else begin
      if (state != IDLE && wrt_smpl) begin
        hold <= smpl_in;
        pend <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (pend) begin
            if (wrt_smpl) hold <= smpl_in;
            else          pend <= 1'b0;
          end
          if (wr_en) begin
            new_ptr <= ptr_inc(new_ptr);
            if (full) begin
              old_ptr <= ptr_inc(old_ptr);
              state   <= PRIME;
            end else begin
              cnt <= cnt + 1'b1;
              if (cnt == CNT_W'(DEPTH - 1)) begin
                full  <= 1'b1;
                state <= PRIME;
              end
            end
          end
        end
        PRIME: begin
          smpl_out   <= rd_data;
          rd_ptr     <= ptr_inc(old_ptr);
          seq_cnt    <= CNT_W'(1);
          sequencing <= 1'b1;
          state      <= SEQ;
        end
        SEQ: begin
          if (seq_cnt == CNT_W'(DEPTH)) begin
            sequencing <= 1'b0;
            state      <= IDLE;
          end else begin
            smpl_out <= rd_data;
            rd_ptr   <= ptr_inc(rd_ptr);
            seq_cnt  <= seq_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_smpl_queue.sv
// Bench for smpl_queue at DEPTH=8: directed windows plus random strobes against a window model.
module tb_smpl_queue;

  localparam int D = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wrt_smpl = 1'b0;
  logic [15:0] smpl_in = '0;
  logic        sequencing;
  logic [15:0] smpl_out;
  logic        full;

  int vectors = 0;
  int miscompares = 0;

  smpl_queue #(
    .DEPTH (D),
    .ADDR_W(3),
    .DATA_W(16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wrt_smpl  (wrt_smpl),
    .smpl_in   (smpl_in),
    .sequencing(sequencing),
    .smpl_out  (smpl_out),
    .full      (full)
  );

  always #5 clk = ~clk;

  // Model: last D samples, one hold slot, busy window of DEPTH+2 cycles after a trigger.
  logic [15:0] win_q[$];
  logic [15:0] snap[$];
  logic [15:0] hold_m = '0;
  bit          pend_m = 0;
  int          idle_from = 0;
  int          seq_start = -1000;
  int          cyc = 0;
  bit          started = 0;
  logic        e_seq = 1'b0;
  logic        e_full = 1'b0;
  logic [15:0] e_out = '0;
  logic [15:0] last_out = '0;
  logic [15:0] seen[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic chk_seen(input string name, input logic [15:0] exp[$]);
    vectors++;
    if (seen.size() != exp.size()) begin
      miscompares++;
      $display("FAIL %s: got %0d window samples expected %0d", name, seen.size(), exp.size());
    end else begin
      for (int i = 0; i < exp.size(); i++) begin
        if (seen[i] !== exp[i]) begin
          miscompares++;
          $display("FAIL %s[%0d]: got %h expected %h", name, i, seen[i], exp[i]);
          break;
        end
      end
    end
    seen.delete();
  endtask

  initial begin
    logic [15:0] val;
    bit          has;
    int          d;
    forever begin
      @(posedge clk);
      started = 1;
      if (rst) begin
        win_q.delete();
        snap.delete();
        pend_m    = 0;
        hold_m    = '0;
        idle_from = 0;
        seq_start = -1000;
        last_out  = '0;
        e_seq     = 1'b0;
        e_out     = '0;
        e_full    = 1'b0;
      end else begin
        if (cyc >= idle_from) begin
          has = 0;
          if (pend_m) begin
            val = hold_m;
            has = 1;
            if (wrt_smpl) hold_m = smpl_in;
            else          pend_m = 0;
          end else if (wrt_smpl) begin
            val = smpl_in;
            has = 1;
          end
          if (has) begin
            if (win_q.size() == D) void'(win_q.pop_front());
            win_q.push_back(val);
            if (win_q.size() == D) begin
              snap      = win_q;
              seq_start = cyc + 2;
              idle_from = cyc + D + 2;
            end
          end
        end else if (wrt_smpl) begin
          hold_m = smpl_in;
          pend_m = 1;
        end
        d      = cyc + 1;
        e_full = (win_q.size() == D);
        if (seq_start >= 0 && d >= seq_start && d < seq_start + D) begin
          e_seq    = 1'b1;
          last_out = snap[d - seq_start];
        end else begin
          e_seq = 1'b0;
        end
        e_out = last_out;
      end
      cyc++;
    end
  end

  // Per-cycle comparison against the model, plus a log of streamed samples.
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        if (rst) begin
          chk("sequencing", {15'b0, sequencing}, 16'd0);
          chk("smpl_out", smpl_out, 16'd0);
          chk("full", {15'b0, full}, 16'd0);
        end else begin
          chk("sequencing", {15'b0, sequencing}, {15'b0, e_seq});
          chk("smpl_out", smpl_out, e_out);
          chk("full", {15'b0, full}, {15'b0, e_full});
        end
        if (sequencing) seen.push_back(smpl_out);
      end
    end
  end

  task automatic wr(input logic [15:0] v);
    wrt_smpl = 1'b1;
    smpl_in  = v;
    @(negedge clk);
    wrt_smpl = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [15:0] exp_q[$];
    int          dens;

    idle(2);
    rst = 1'b0;

    for (int v = 1; v <= 7; v++) wr(16'(v));
    idle(12);
    chk("full_after7", {15'b0, full}, 16'd0);
    exp_q.delete();
    chk_seen("no_window_after7", exp_q);

    wr(16'd8);
    idle(12);
    chk("full_after8", {15'b0, full}, 16'd1);
    exp_q.delete();
    for (int v = 1; v <= 8; v++) exp_q.push_back(16'(v));
    chk_seen("window_1_8", exp_q);

    wr(16'd9);
    idle(12);
    exp_q.delete();
    for (int v = 2; v <= 9; v++) exp_q.push_back(16'(v));
    chk_seen("window_2_9", exp_q);

    // 11 and 12 arrive while 3..10 streams; 12 replaces 11 in the hold slot.
    wr(16'd10);
    idle(3);
    wr(16'd11);
    wr(16'd12);
    idle(24);
    exp_q.delete();
    for (int v = 3; v <= 10; v++) exp_q.push_back(16'(v));
    for (int v = 4; v <= 10; v++) exp_q.push_back(16'(v));
    exp_q.push_back(16'd12);
    chk_seen("window_3_10_then_held12", exp_q);

    wr(16'd20);
    idle(4);
    chk("seq_4th_cycle", {15'b0, sequencing}, 16'd1);
    chk("out_4th_cycle", smpl_out, 16'd8);
    #1 rst = 1'b1;
    #1;
    chk("rst_async_seq", {15'b0, sequencing}, 16'd0);
    chk("rst_async_out", smpl_out, 16'd0);
    chk("rst_async_full", {15'b0, full}, 16'd0);
    idle(2);
    rst = 1'b0;
    seen.delete();
    for (int v = 0; v < 7; v++) wr(16'($urandom));
    idle(12);
    chk("full_refill7", {15'b0, full}, 16'd0);
    exp_q.delete();
    chk_seen("no_window_refill7", exp_q);

    for (int i = 0; i < 900; i++) begin
      dens = (i < 300) ? 2 : (i < 600) ? 11 : 4;
      if ($urandom_range(0, 299) == 0) begin
        wrt_smpl = 1'b0;
        #1 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end else begin
        wrt_smpl = ($urandom_range(0, dens - 1) == 0);
        smpl_in  = 16'($urandom);
        @(negedge clk);
      end
    end
    wrt_smpl = 1'b0;
    idle(30);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
